// File: rtl/mips_pipeline_hazard_if.sv
// Observation/enable bundle between the five-stage Mips datapath and its
// sequencing controller; the controller uses the slave modport.
interface mips_pipeline_hazard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] ifIdRs;
  logic [REG_W-1:0] ifIdRt;
  logic             ifIdUsesRt;
  logic             idExMemRead;
  logic [REG_W-1:0] idExRt;
  logic             branchTaken;
  logic             exMemMemOp;
  logic             memAck;
  logic             memReq;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             ifIdFlush;
  logic             idExBubble;
  logic             pipeWrite;
  logic             fault;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;

  // Pipeline/datapath side: publishes register fields and the RAM ack.
  modport master (
    output ifIdRs, ifIdRt, ifIdUsesRt, idExMemRead, idExRt,
    output branchTaken, exMemMemOp, memAck,
    input  memReq, pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeWrite,
    input  fault, stallCycles, flushCount
  );

  // Controller side.
  modport slave (
    input  ifIdRs, ifIdRt, ifIdUsesRt, idExMemRead, idExRt,
    input  branchTaken, exMemMemOp, memAck,
    output memReq, pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeWrite,
    output fault, stallCycles, flushCount
  );
endinterface

// File: rtl/mips_pipeline_hazard.sv
// Stall/flush/bubble sequencing for the five-stage Mips core, with a memory
// wait timeout fault. Define MIPS_PIPELINE_HAZARD_PERF_EN for the perf counters.
module mips_pipeline_hazard #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32,
  parameter int REG_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_pipeline_hazard_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt_q;
  logic [7:0] wait_cnt_d;

  logic [REG_W-1:0] ex_rt;
  logic             load_use;

  logic mem_req;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic pipe_write;
  logic fault_out;

  assign ex_rt    = hz.idExRt;
  assign load_use = hz.idExMemRead && (ex_rt != '0) &&
                    ((ex_rt == hz.ifIdRs) || (hz.ifIdUsesRt && (ex_rt == hz.ifIdRt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Freeze is the all-zero default; only the unfrozen RUN path raises enables.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req      = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_write   = 1'b0;
    fault_out    = 1'b0;
    unique case (state_q)
      RUN: begin
        mem_req = hz.exMemMemOp;
        if (hz.exMemMemOp && !hz.memAck) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          pipe_write = 1'b1;
          if (load_use) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = hz.branchTaken;
          end
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        // The ack cycle stays frozen; the access retires on the following RUN cycle.
        if (hz.memAck) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      FAULT: begin
        fault_out = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign hz.memReq     = mem_req;
  assign hz.pcWrite    = pc_write;
  assign hz.ifIdWrite  = if_id_write;
  assign hz.ifIdFlush  = if_id_flush;
  assign hz.idExBubble = id_ex_bubble;
  assign hz.pipeWrite  = pipe_write;
  assign hz.fault      = fault_out;

`ifdef MIPS_PIPELINE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (if_id_flush) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign hz.stallCycles = stall_cnt_q;
  assign hz.flushCount  = flush_cnt_q;
`else
  assign hz.stallCycles = {CNT_W{1'b0}};
  assign hz.flushCount  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mips_pipeline_hazard.sv
// Randomised and directed bench for mips_pipeline_hazard against a behavioural
// model of the stall/flush/freeze rules and the saturating perf counters.
module tb_mips_pipeline_hazard;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;
  localparam int REG_W    = 5;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_pipeline_hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  mips_pipeline_hazard #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle();
    bus.ifIdRs      = '0;
    bus.ifIdRt      = '0;
    bus.ifIdUsesRt  = 1'b0;
    bus.idExMemRead = 1'b0;
    bus.idExRt      = '0;
    bus.branchTaken = 1'b0;
    bus.exMemMemOp  = 1'b0;
    bus.memAck      = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    next_cycle();
    rst = 1'b1;
    idle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Behavioural model: the pipeline is either running, waiting on RAM for
  // some number of cycles, or dead; counters are plain saturating integers.
  initial begin
    bit m_valid   = 0;
    bit m_waiting = 0;
    bit m_dead    = 0;
    int m_waited  = 0;
    int m_stall   = 0;
    int m_flush   = 0;
    int e_req, e_pc, e_ifw, e_fl, e_bub, e_pw, e_fault, e_sc, e_fc;
    bit hazard;
    forever begin
      @(negedge clk);
      hazard = bus.idExMemRead && (bus.idExRt != 0) &&
               ((bus.idExRt == bus.ifIdRs) || (bus.ifIdUsesRt && (bus.idExRt == bus.ifIdRt)));
      e_req = 0; e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_pw = 0;
      e_fault = m_dead ? 1 : 0;
      if (m_dead) begin
        e_req = 0;
      end else if (m_waiting || (bus.exMemMemOp && !bus.memAck)) begin
        e_req = 1;
      end else begin
        e_req = int'(bus.exMemMemOp);
        e_pw  = 1;
        if (hazard) e_bub = 1;
        else begin
          e_pc = 1; e_ifw = 1; e_fl = int'(bus.branchTaken);
        end
      end
`ifdef MIPS_PIPELINE_HAZARD_PERF_EN
      e_sc = m_stall; e_fc = m_flush;
`else
      e_sc = 0; e_fc = 0;
`endif
      if (m_valid) begin
        chk("memReq", int'(bus.memReq), e_req);
        chk("pcWrite", int'(bus.pcWrite), e_pc);
        chk("ifIdWrite", int'(bus.ifIdWrite), e_ifw);
        chk("ifIdFlush", int'(bus.ifIdFlush), e_fl);
        chk("idExBubble", int'(bus.idExBubble), e_bub);
        chk("pipeWrite", int'(bus.pipeWrite), e_pw);
        chk("fault", int'(bus.fault), e_fault);
        chk("stallCycles", int'(bus.stallCycles), e_sc);
        chk("flushCount", int'(bus.flushCount), e_fc);
      end
      if (rst) begin
        m_valid = 1; m_waiting = 0; m_dead = 0; m_waited = 0;
        m_stall = 0; m_flush = 0;
      end else if (m_valid) begin
        if (e_pc == 0 && m_stall < CMAX) m_stall++;
        if (e_fl == 1 && m_flush < CMAX) m_flush++;
        if (m_dead) begin
          m_dead = 1;
        end else if (m_waiting) begin
          if (bus.memAck) m_waiting = 0;
          else if (m_waited >= WAIT_MAX) begin m_waiting = 0; m_dead = 1; end
          else m_waited++;
        end else if (bus.exMemMemOp && !bus.memAck) begin
          m_waiting = 1; m_waited = 1;
        end
      end
    end
  end

  initial begin
    int frozen;
    int first_fault;
    int ack_pct;
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_pcWrite", int'(bus.pcWrite), 1);
    chk("rst_ifIdWrite", int'(bus.ifIdWrite), 1);
    chk("rst_pipeWrite", int'(bus.pipeWrite), 1);
    chk("rst_memReq", int'(bus.memReq), 0);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_stallCycles", int'(bus.stallCycles), 0);

    next_cycle();
    bus.idExMemRead = 1'b1; bus.idExRt = 5'd8; bus.ifIdRs = 5'd8;
    @(negedge clk);
    chk("lu_pcWrite", int'(bus.pcWrite), 0);
    chk("lu_bubble", int'(bus.idExBubble), 1);

    next_cycle();
    bus.idExRt = 5'd0; bus.ifIdRs = 5'd0;
    @(negedge clk);
    chk("lu_r0_pcWrite", int'(bus.pcWrite), 1);
    chk("lu_r0_bubble", int'(bus.idExBubble), 0);

    next_cycle();
    idle();
    bus.branchTaken = 1'b1;
    @(negedge clk);
    chk("br_flush", int'(bus.ifIdFlush), 1);

    next_cycle();
    bus.idExMemRead = 1'b1; bus.idExRt = 5'd9; bus.ifIdRt = 5'd9; bus.ifIdUsesRt = 1'b1;
    @(negedge clk);
    chk("br_lu_flush", int'(bus.ifIdFlush), 0);
    chk("br_lu_pcWrite", int'(bus.pcWrite), 0);

    next_cycle();
    idle();
    @(negedge clk);
`ifdef MIPS_PIPELINE_HAZARD_PERF_EN
    chk("perf_stall_2", int'(bus.stallCycles), 2);
    chk("perf_flush_1", int'(bus.flushCount), 1);
`else
    chk("perf_stall_off", int'(bus.stallCycles), 0);
    chk("perf_flush_off", int'(bus.flushCount), 0);
`endif

    // Ack arrives three cycles after the request: four frozen cycles.
    pulse_reset();
    frozen = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      bus.exMemMemOp = 1'b1;
      bus.memAck     = (i >= 3);
      @(negedge clk);
      if (!bus.pcWrite && !bus.pipeWrite && !bus.ifIdWrite) frozen++;
      chk("mem_req_held", int'(bus.memReq), 1);
    end
    next_cycle();
    idle();
    @(negedge clk);
    chk("mem_frozen_cycles", frozen, 4);
`ifdef MIPS_PIPELINE_HAZARD_PERF_EN
    chk("mem_perf_stall", int'(bus.stallCycles), 4);
`else
    chk("mem_perf_stall", int'(bus.stallCycles), 0);
`endif

    // Ack never arrives: fault on the 17th cycle (index 16), bounded search.
    pulse_reset();
    first_fault = -1;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      bus.exMemMemOp = 1'b1;
      bus.memAck     = 1'b0;
      @(negedge clk);
      if (bus.fault && first_fault < 0) first_fault = i;
      if (first_fault >= 0) break;
    end
    chk("fault_latency", first_fault, 16);
    chk("fault_memReq", int'(bus.memReq), 0);
    chk("fault_pcWrite", int'(bus.pcWrite), 0);
    repeat (3) begin
      next_cycle();
      bus.memAck = 1'b1;
    end
    @(negedge clk);
    chk("fault_sticky", int'(bus.fault), 1);
`ifdef MIPS_PIPELINE_HAZARD_PERF_EN
    chk("perf_saturated", int'(bus.stallCycles), CMAX);
`else
    chk("perf_saturated", int'(bus.stallCycles), 0);
`endif
    pulse_reset();
    @(negedge clk);
    chk("fault_cleared", int'(bus.fault), 0);
    chk("fault_cleared_pc", int'(bus.pcWrite), 1);

    // Reset in the middle of a memory wait, with the request still pending.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.exMemMemOp = 1'b1;
      bus.memAck     = 1'b0;
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bus.memAck = 1'b1;
    @(negedge clk);
    chk("midwait_rst_memReq", int'(bus.memReq), 1);
    chk("midwait_rst_pcWrite", int'(bus.pcWrite), 1);
    chk("midwait_rst_stall", int'(bus.stallCycles), 0);

    // Random traffic with ack likelihood changing every 200 cycles.
    for (int i = 0; i < 3000; i++) begin
      ack_pct = ((i / 200) % 3 == 0) ? 60 : (((i / 200) % 3 == 1) ? 25 : 3);
      next_cycle();
      rst             = ($urandom_range(0, 199) == 0);
      bus.ifIdRs      = REG_W'($urandom_range(0, 3));
      bus.ifIdRt      = REG_W'($urandom_range(0, 3));
      bus.idExRt      = REG_W'($urandom_range(0, 3));
      bus.ifIdUsesRt  = ($urandom_range(0, 1) == 1);
      bus.idExMemRead = ($urandom_range(0, 2) == 0);
      bus.branchTaken = ($urandom_range(0, 3) == 0);
      bus.exMemMemOp  = ($urandom_range(0, 2) == 0);
      bus.memAck      = ($urandom_range(0, 99) < ack_pct);
    end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
